// File: rtl/wb_rr_arbiter_if.sv
// wb_rr_arbiter_if: the Wishbone signals around wb_rr_arbiter.
// Lane i of a packed master field sits at [w*i +: w].
//   master : arbiter side (owns the shared slave bus, acks masters)
//   slave  : environment side (requesting masters + shared slave)
interface wb_rr_arbiter_if #(
   parameter int NUM_MASTERS = 2
);
   logic [NUM_MASTERS-1:0]    m_cyc_i;
   logic [NUM_MASTERS-1:0]    m_stb_i;
   logic [NUM_MASTERS-1:0]    m_we_i;
   logic [4*NUM_MASTERS-1:0]  m_sel_i;
   logic [32*NUM_MASTERS-1:0] m_adr_i;
   logic [32*NUM_MASTERS-1:0] m_dat_i;
   logic [31:0]               m_dat_o;
   logic [NUM_MASTERS-1:0]    m_ack_o;
   logic [NUM_MASTERS-1:0]    m_err_o;

   logic                      s_cyc_o;
   logic                      s_stb_o;
   logic                      s_we_o;
   logic [3:0]                s_sel_o;
   logic [31:0]               s_adr_o;
   logic [31:0]               s_dat_o;
   logic [31:0]               s_dat_i;
   logic                      s_ack_i;

   modport master (
      input  m_cyc_i, m_stb_i, m_we_i,
      input  m_sel_i, m_adr_i, m_dat_i,
      output m_dat_o, m_ack_o, m_err_o,
      output s_cyc_o, s_stb_o, s_we_o,
      output s_sel_o, s_adr_o, s_dat_o,
      input  s_dat_i, s_ack_i
   );

   modport slave (
      output m_cyc_i, m_stb_i, m_we_i,
      output m_sel_i, m_adr_i, m_dat_i,
      input  m_dat_o, m_ack_o, m_err_o,
      input  s_cyc_o, s_stb_o, s_we_o,
      input  s_sel_o, s_adr_o, s_dat_o,
      output s_dat_i, s_ack_i
   );
endinterface

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin lock arbiter sharing one Wishbone slave
// among NUM_MASTERS masters, with a stalled-strobe watchdog.
//   wb_clk_i / wb_rst_i : clock, async active-high reset
//   bus                 : master/slave Wishbone signals (master modport)
//   grant_o             : registered one-hot grant
//   timeout_o           : one-cycle pulse when the watchdog fires
module wb_rr_arbiter #(
   parameter int NUM_MASTERS    = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   wb_rr_arbiter_if.master        bus,
   output logic [NUM_MASTERS-1:0] grant_o,
   output logic                   timeout_o
);

   localparam int IW =
      (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int CW =
      (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);
   localparam logic [IW-1:0] LAST_RST = IW'(NUM_MASTERS - 1);

   typedef enum logic [1:0] {
      IDLE,
      BUS,
      DRAIN
   } state_t;

   state_t                 state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [IW-1:0]          last_q, last_d;
   logic [IW-1:0]          pick;
   logic [CW-1:0]          cnt_q, cnt_d;

   logic                   g_cyc, g_stb, g_we;
   logic [3:0]             g_sel;
   logic [31:0]            g_adr, g_dat;

   logic                   s_cyc, s_stb, s_we;
   logic [3:0]             s_sel;
   logic [31:0]            s_adr, s_dat;
   logic [NUM_MASTERS-1:0] ack, err;
   logic                   tmo;
   logic                   expire;

   // last_q always names the current owner while in BUS/DRAIN
   assign g_cyc = bus.m_cyc_i[last_q];
   assign g_stb = bus.m_stb_i[last_q];
   assign g_we  = bus.m_we_i[last_q];
   assign g_sel = bus.m_sel_i[4*last_q +: 4];
   assign g_adr = bus.m_adr_i[32*last_q +: 32];
   assign g_dat = bus.m_dat_i[32*last_q +: 32];

   // Walk downward so the smallest offset from last+1 wins
   always_comb begin
      pick = last_q;
      for (int k = NUM_MASTERS; k >= 1; k--) begin
         if (bus.m_cyc_i[(int'(last_q) + k) % NUM_MASTERS])
            pick = IW'((int'(last_q) + k) % NUM_MASTERS);
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      cnt_d   = '0;
      s_cyc   = 1'b0;
      s_stb   = 1'b0;
      s_we    = 1'b0;
      s_sel   = '0;
      s_adr   = '0;
      s_dat   = '0;
      ack     = '0;
      err     = '0;
      tmo     = 1'b0;
      expire  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (|bus.m_cyc_i) begin
               state_d       = BUS;
               grant_d       = '0;
               grant_d[pick] = 1'b1;
               last_d        = pick;
            end
         end

         BUS: begin
            // a same-cycle ack beats the watchdog
            expire = WD_EN && g_cyc && g_stb
                     && !bus.s_ack_i
                     && (cnt_q == TMAX);
            s_cyc  = g_cyc && !expire;
            s_stb  = g_stb && !expire;
            s_we   = g_we;
            s_sel  = g_sel;
            s_adr  = g_adr;
            s_dat  = g_dat;
            ack[last_q] = bus.s_ack_i;
            if (!g_cyc) begin
               state_d = IDLE;
               grant_d = '0;
            end else if (expire) begin
               state_d     = DRAIN;
               err[last_q] = 1'b1;
               tmo         = 1'b1;
            end else if (g_stb && !bus.s_ack_i) begin
               cnt_d = (cnt_q == TMAX) ? cnt_q
                                       : cnt_q + 1'b1;
            end
         end

         DRAIN: begin
            if (!g_cyc) begin
               state_d = IDLE;
               grant_d = '0;
            end
         end

         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= LAST_RST;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.s_cyc_o = s_cyc;
   assign bus.s_stb_o = s_stb;
   assign bus.s_we_o  = s_we;
   assign bus.s_sel_o = s_sel;
   assign bus.s_adr_o = s_adr;
   assign bus.s_dat_o = s_dat;
   assign bus.m_dat_o = bus.s_dat_i;
   assign bus.m_ack_o = ack;
   assign bus.m_err_o = err;
   assign grant_o     = grant_q;
   assign timeout_o   = tmo;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed test-plan scenarios plus random traffic,
// every cycle compared against a transaction-level ownership model.
module tb_wb_rr_arbiter;
   localparam int N  = 2;
   localparam int TO = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] grant;
   logic         tmo;
   int           n_vec = 0;
   int           n_bad = 0;

   // reference model: who owns the slave, whether the watchdog
   // killed the cycle, consecutive stalled strobe cycles, last owner
   int           own   = -1;
   bit           dead  = 1'b0;
   int           stall = 0;
   int           last  = N - 1;

   wb_rr_arbiter_if #(.NUM_MASTERS(N)) bus ();

   wb_rr_arbiter #(
      .NUM_MASTERS(N),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .bus      (bus),
      .grant_o  (grant),
      .timeout_o(tmo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h @%0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      bus.m_cyc_i = '0;
      bus.m_stb_i = '0;
      bus.m_we_i  = '0;
      bus.m_sel_i = '0;
      bus.m_adr_i = '0;
      bus.m_dat_i = '0;
      bus.s_ack_i = 1'b0;
   endtask

   always @(negedge clk) begin : ref_model
      logic [N-1:0] e_gnt, e_ack, e_err;
      logic         e_cyc, e_stb, e_we, e_tmo, fire;
      logic [3:0]   e_sel;
      logic [31:0]  e_adr, e_dat;
      e_gnt = '0;
      e_ack = '0;
      e_err = '0;
      e_cyc = 1'b0;
      e_stb = 1'b0;
      e_we  = 1'b0;
      e_tmo = 1'b0;
      fire  = 1'b0;
      e_sel = '0;
      e_adr = '0;
      e_dat = '0;
      if (rst) begin
         own   = -1;
         dead  = 1'b0;
         stall = 0;
         last  = N - 1;
      end else if (own >= 0) begin
         e_gnt[own] = 1'b1;
         if (!dead) begin
            fire = bus.m_cyc_i[own] && bus.m_stb_i[own]
                   && !bus.s_ack_i && (stall == TO);
            e_cyc = bus.m_cyc_i[own] && !fire;
            e_stb = bus.m_stb_i[own] && !fire;
            e_we  = bus.m_we_i[own];
            e_sel = bus.m_sel_i[4*own +: 4];
            e_adr = bus.m_adr_i[32*own +: 32];
            e_dat = bus.m_dat_i[32*own +: 32];
            e_ack[own] = bus.s_ack_i;
            e_err[own] = fire;
            e_tmo      = fire;
         end
      end
      check("grant", grant, e_gnt);
      check("s_cyc", bus.s_cyc_o, e_cyc);
      check("s_stb", bus.s_stb_o, e_stb);
      check("s_we", bus.s_we_o, e_we);
      check("s_sel", bus.s_sel_o, e_sel);
      check("s_adr", bus.s_adr_o, e_adr);
      check("s_dat", bus.s_dat_o, e_dat);
      check("m_ack", bus.m_ack_o, e_ack);
      check("m_err", bus.m_err_o, e_err);
      check("timeout", tmo, e_tmo);
      check("m_dat", bus.m_dat_o, bus.s_dat_i);
      if (!rst) begin
         if (own < 0) begin
            for (int k = 1; k <= N; k++) begin
               if (own < 0 && bus.m_cyc_i[(last + k) % N]) begin
                  own   = (last + k) % N;
                  last  = own;
                  stall = 0;
               end
            end
         end else if (!bus.m_cyc_i[own]) begin
            own   = -1;
            dead  = 1'b0;
            stall = 0;
         end else if (fire) begin
            dead = 1'b1;
         end else if (!dead) begin
            if (bus.m_stb_i[own] && !bus.s_ack_i)
               stall = (stall < TO) ? stall + 1 : stall;
            else
               stall = 0;
         end
      end
   end

   logic [N-1:0] alt_cyc [8];
   logic [N-1:0] alt_gnt [8];

   initial begin
      alt_cyc = '{2'b11, 2'b10, 2'b10, 2'b11,
                  2'b01, 2'b01, 2'b10, 2'b10};
      alt_gnt = '{2'b01, 2'b00, 2'b10, 2'b10,
                  2'b00, 2'b01, 2'b00, 2'b10};
      idle_in();
      bus.s_dat_i = '0;
      rst = 1'b1;
      step();
      step();
      check("rst_grant", grant, 2'b00);
      check("rst_scyc", bus.s_cyc_o, 1'b0);
      rst = 1'b0;

      // single master M1 write
      bus.m_cyc_i = 2'b10;
      bus.m_stb_i = 2'b10;
      bus.m_we_i  = 2'b10;
      bus.m_sel_i = 8'hF0;
      bus.m_adr_i = {32'h3000_0000, 32'h0};
      bus.m_dat_i = {32'h0000_0005, 32'h0};
      step();
      check("w_grant", grant, 2'b10);
      check("w_adr", bus.s_adr_o, 32'h3000_0000);
      check("w_dat", bus.s_dat_o, 32'h5);
      check("w_noack", bus.m_ack_o, 2'b00);
      step();
      bus.s_ack_i = 1'b1;
      #1;
      check("w_ack", bus.m_ack_o, 2'b10);
      step();
      idle_in();
      step();
      step();

      // contention right after reset: M0 first, then alternation
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus.m_cyc_i = alt_cyc[i];
         step();
         check("alt_grant", grant, alt_gnt[i]);
      end
      idle_in();
      step();
      step();

      // locked burst: M0 holds through 4 beats while M1 waits
      bus.m_cyc_i = 2'b11;
      bus.m_stb_i = 2'b01;
      bus.s_ack_i = 1'b1;
      step();
      for (int b = 0; b < 4; b++) begin
         check("lock_grant", grant, 2'b01);
         check("lock_ack", bus.m_ack_o, 2'b01);
         step();
      end
      bus.m_cyc_i = 2'b10;
      bus.m_stb_i = 2'b00;
      bus.s_ack_i = 1'b0;
      step();
      check("lock_gap", grant, 2'b00);
      step();
      check("lock_next", grant, 2'b10);
      idle_in();
      step();
      step();

      // watchdog expiry with a silent slave
      bus.m_cyc_i = 2'b01;
      bus.m_stb_i = 2'b01;
      step();
      for (int k = 0; k < 6; k++) begin
         check("to_pulse", tmo, k == 4);
         check("to_err", bus.m_err_o, (k == 4) ? 2'b01 : 2'b00);
         check("to_scyc", bus.s_cyc_o, k < 4);
         check("to_grant", grant, 2'b01);
         step();
      end
      idle_in();
      step();
      check("to_release", grant, 2'b00);
      step();

      // ack on the expiry cycle wins
      bus.m_cyc_i = 2'b01;
      bus.m_stb_i = 2'b01;
      step();
      for (int k = 0; k < 6; k++) begin
         bus.s_ack_i = (k == 4);
         #1;
         check("race_ack", bus.m_ack_o, (k == 4) ? 2'b01 : 2'b00);
         check("race_err", bus.m_err_o, 2'b00);
         check("race_tmo", tmo, 1'b0);
         check("race_scyc", bus.s_cyc_o, 1'b1);
         step();
      end
      idle_in();
      step();
      step();

      // read data routed to M1 only
      bus.m_cyc_i = 2'b10;
      bus.m_stb_i = 2'b10;
      bus.s_dat_i = 32'hDEAD_BEEF;
      step();
      bus.s_ack_i = 1'b1;
      #1;
      check("rd_dat", bus.m_dat_o, 32'hDEAD_BEEF);
      check("rd_ack", bus.m_ack_o, 2'b10);
      idle_in();
      step();
      step();

      // reset in the middle of M1's cycle
      bus.m_cyc_i = 2'b10;
      bus.m_stb_i = 2'b10;
      step();
      bus.s_ack_i = 1'b1;
      #1;
      check("mid_ack", bus.m_ack_o, 2'b10);
      rst = 1'b1;
      #1;
      check("mid_scyc", bus.s_cyc_o, 1'b0);
      check("mid_grant", grant, 2'b00);
      check("mid_ack0", bus.m_ack_o, 2'b00);
      bus.m_cyc_i = 2'b11;
      bus.s_ack_i = 1'b0;
      step();
      rst = 1'b0;
      step();
      check("post_rst", grant, 2'b01);
      idle_in();
      step();
      step();

      // random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (bus.m_cyc_i[i]) begin
               if ($urandom_range(0, (c < 1500) ? 5 : 11) == 0)
                  bus.m_cyc_i[i] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
               bus.m_cyc_i[i] = 1'b1;
            end
            bus.m_stb_i[i] = bus.m_cyc_i[i]
                             && ($urandom_range(0, 7) != 0);
            bus.m_we_i[i]  = 1'($urandom);
            bus.m_sel_i[4*i +: 4]   = 4'($urandom);
            bus.m_adr_i[32*i +: 32] = $urandom;
            bus.m_dat_i[32*i +: 32] = $urandom;
         end
         bus.s_ack_i = (c < 1500) ? ($urandom_range(0, 1) == 1)
                                  : ($urandom_range(0, 9) == 0);
         bus.s_dat_i = $urandom;
         rst = ($urandom_range(0, 399) == 0);
         step();
      end
      rst = 1'b0;
      idle_in();
      step();
      step();
      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end
endmodule
